instr_mem_loader: RTL and testbench

Parametrised instruction memory with a sequential program-load port and a registered fetch port. It is the opcode store in front of the exe_engine. A loader streams a program in through a valid/ready handshake with an auto-incrementing write pointer. The execution engine then fetches opcodes by program pointer, and any fetch beyond the loaded program length, or outside READY, is flagged as an error.

---
 rtl/instr_mem_loader_if.sv | 29 ++
 rtl/instr_mem_loader.sv | 129 ++++++++++++
 tb/tb_instr_mem_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Load/fetch bus between the program loader / exe_engine (master) and the
// instruction store (slave).
interface instr_mem_loader_if #(
  parameter int OP_W   = 26,
  parameter int ADDR_W = 4
);
  logic              load_start;
  logic              load_valid;
  logic [OP_W-1:0]   load_data;
  logic              load_ready;
  logic              load_end;
  logic [ADDR_W:0]   prog_len;
  logic              busy;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [OP_W-1:0]   opcode;
  logic              fetch_err;

  modport master (
    output load_start, load_valid, load_data, load_end, fetch_req, fetch_addr,
    input  load_ready, prog_len, busy, fetch_valid, opcode, fetch_err
  );

  modport slave (
    input  load_start, load_valid, load_data, load_end, fetch_req, fetch_addr,
    output load_ready, prog_len, busy, fetch_valid, opcode, fetch_err
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Opcode store: sequential program load with auto-incrementing pointer and a
// one-cycle registered fetch port that flags out-of-program accesses.
module instr_mem_loader #(
  parameter int  OP_W   = 26,
  parameter int  DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_mem_loader_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_W  = (ADDR_W+1)'(DEPTH - 1);

  logic [OP_W-1:0] mem_q [0:DEPTH-1];

  state_e          state_q, state_d;
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] prog_len_q, prog_len_d;
  logic            load_ready_q, load_ready_d;
  logic            busy_q, busy_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            fetch_err_q, fetch_err_d;
  logic [OP_W-1:0] opcode_q, opcode_d;
  logic            accept_s;
  logic            fetch_ok_s;

  // Load FSM next state, write pointer and program length.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    prog_len_d = prog_len_q;
    accept_s   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (bus.load_start) begin
          wptr_d     = '0;
          prog_len_d = '0;
        end else begin
          accept_s = bus.load_valid & load_ready_q;
          if (accept_s) begin
            wptr_d = wptr_q + (ADDR_W+1)'(1);
          end else begin
            wptr_d = wptr_q;
          end
          // wptr_d already counts a word accepted alongside load_end.
          if (bus.load_end || (accept_s && (wptr_q == LAST_W))) begin
            state_d    = ST_READY;
            prog_len_d = wptr_d;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_EMPTY, ST_READY: begin
        if (bus.load_start) begin
          state_d    = ST_LOAD;
          wptr_d     = '0;
          prog_len_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = ST_EMPTY;
        wptr_d     = '0;
        prog_len_d = '0;
      end
    endcase
    load_ready_d = (state_d == ST_LOAD) && (wptr_d < DEPTH_W);
    busy_d       = (state_d == ST_LOAD);
  end

  // Fetch qualification; addresses >= prog_len (hence >= DEPTH) are rejected.
  always_comb begin
    fetch_ok_s = bus.fetch_req && (state_q == ST_READY) && !bus.load_start &&
                 ({1'b0, bus.fetch_addr} < prog_len_q);
    fetch_valid_d = fetch_ok_s;
    fetch_err_d   = bus.fetch_req && !fetch_ok_s;
    if (fetch_ok_s) begin
      opcode_d = mem_q[bus.fetch_addr];
    end else begin
      opcode_d = opcode_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_EMPTY;
      wptr_q        <= '0;
      prog_len_q    <= '0;
      load_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      opcode_q      <= '0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      prog_len_q    <= prog_len_d;
      load_ready_q  <= load_ready_d;
      busy_q        <= busy_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      opcode_q      <= opcode_d;
    end
  end

  // Opcode array write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= bus.load_data;
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.prog_len    = prog_len_q;
  assign bus.busy        = busy_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.opcode      = opcode_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Drives a DEPTH=16 and a DEPTH=10 instance with shared stimulus and compares
// both against a word-list reference model.
module tb_instr_mem_loader;
  localparam int OP_W = 26;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            ls = 1'b0, lv = 1'b0, le = 1'b0, fr = 1'b0;
  logic [OP_W-1:0] ld = '0;
  logic [AW-1:0]   fa = '0;

  instr_mem_loader_if #(.OP_W(OP_W), .ADDR_W(AW)) b16 ();
  instr_mem_loader_if #(.OP_W(OP_W), .ADDR_W(AW)) b10 ();

  assign b16.load_start = ls;  assign b10.load_start = ls;
  assign b16.load_valid = lv;  assign b10.load_valid = lv;
  assign b16.load_data  = ld;  assign b10.load_data  = ld;
  assign b16.load_end   = le;  assign b10.load_end   = le;
  assign b16.fetch_req  = fr;  assign b10.fetch_req  = fr;
  assign b16.fetch_addr = fa;  assign b10.fetch_addr = fa;

  instr_mem_loader #(.OP_W(OP_W), .DEPTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(b16));
  instr_mem_loader #(.OP_W(OP_W), .DEPTH(10)) dut10 (.clk(clk), .reset_n(reset_n), .bus(b10));

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model: program as a list of words plus loading/ready flags.
  bit              loading_m [2];
  bit              ready_m   [2];
  int              cnt_m     [2];
  int              len_m     [2];
  logic [OP_W-1:0] prog_m    [2][16];
  logic [OP_W-1:0] op_m      [2];
  bit              fv_m      [2];
  bit              fe_m      [2];
  logic [OP_W-1:0] words     [16];

  function automatic int depth_of(input int k);
    return (k == 0) ? 16 : 10;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      loading_m[k] = 1'b0; ready_m[k] = 1'b0; cnt_m[k] = 0; len_m[k] = 0;
      op_m[k] = '0; fv_m[k] = 1'b0; fe_m[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int d = depth_of(k);
    if (fr) begin
      if (ready_m[k] && !ls && (int'(fa) < len_m[k])) begin
        op_m[k] = prog_m[k][fa]; fv_m[k] = 1'b1; fe_m[k] = 1'b0;
      end else begin
        fv_m[k] = 1'b0; fe_m[k] = 1'b1;
      end
    end else begin
      fv_m[k] = 1'b0; fe_m[k] = 1'b0;
    end
    if (ls) begin
      loading_m[k] = 1'b1; ready_m[k] = 1'b0; cnt_m[k] = 0; len_m[k] = 0;
    end else if (loading_m[k]) begin
      if (lv && cnt_m[k] < d) begin
        prog_m[k][cnt_m[k]] = ld;
        cnt_m[k]++;
      end
      if (le || cnt_m[k] == d) begin
        loading_m[k] = 1'b0; ready_m[k] = 1'b1; len_m[k] = cnt_m[k];
      end
    end
  endtask

  task automatic check_dut(input int k);
    logic lr, bz, fv, fe;
    logic [AW:0] pl;
    logic [OP_W-1:0] op;
    string p;
    p = $sformatf("D%0d", depth_of(k));
    if (k == 0) begin
      lr = b16.load_ready; bz = b16.busy; fv = b16.fetch_valid; fe = b16.fetch_err;
      pl = b16.prog_len; op = b16.opcode;
    end else begin
      lr = b10.load_ready; bz = b10.busy; fv = b10.fetch_valid; fe = b10.fetch_err;
      pl = b10.prog_len; op = b10.opcode;
    end
    check_val({p, ".load_ready"}, 32'(lr), 32'(loading_m[k] && cnt_m[k] < depth_of(k)));
    check_val({p, ".busy"}, 32'(bz), 32'(loading_m[k]));
    check_val({p, ".prog_len"}, 32'(pl), 32'(len_m[k]));
    check_val({p, ".fetch_valid"}, 32'(fv), 32'(fv_m[k]));
    check_val({p, ".fetch_err"}, 32'(fe), 32'(fe_m[k]));
    check_val({p, ".opcode"}, 32'(op), 32'(op_m[k]));
  endtask

  task automatic set_idle();
    ls = 1'b0; lv = 1'b0; le = 1'b0; fr = 1'b0; fa = '0; ld = '0;
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_dut(k);
  endtask

  // Asserts reset between edges (may land mid-load) and checks it acts at once.
  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) check_dut(k);
    set_idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push_word(input logic [OP_W-1:0] w, input logic with_end);
    lv = 1'b1; ld = w; le = with_end;
    tick();
    lv = 1'b0; le = 1'b0;
  endtask

  task automatic start_load();
    ls = 1'b1;
    tick();
    ls = 1'b0;
  endtask

  task automatic fetch(input int a);
    fr = 1'b1; fa = AW'(a);
    tick();
    fr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_idle();
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) check_dut(k);
    apply_reset();

    // Fetch in EMPTY must error.
    fetch(0);
    check_val("empty_fetch_err", 32'(b16.fetch_err), 32'd1);

    // Five-word program.
    start_load();
    for (int i = 1; i <= 5; i++) push_word(OP_W'(i), 1'b0);
    le = 1'b1; tick(); le = 1'b0;
    check_val("len5_prog_len", 32'(b16.prog_len), 32'd5);
    fetch(3);
    check_val("len5_opcode", 32'(b16.opcode), 32'h4);
    check_val("len5_valid", 32'(b16.fetch_valid), 32'd1);
    fetch(5);
    check_val("len5_oob_err", 32'(b16.fetch_err), 32'd1);
    check_val("len5_oob_hold", 32'(b16.opcode), 32'h4);

    // Full load with no load_end, then a stray 17th word.
    start_load();
    for (int i = 0; i < 16; i++) begin
      words[i] = OP_W'($urandom);
      push_word(words[i], 1'b0);
    end
    check_val("full_prog_len", 32'(b16.prog_len), 32'd16);
    check_val("full_load_ready", 32'(b16.load_ready), 32'd0);
    check_val("full10_prog_len", 32'(b10.prog_len), 32'd10);
    push_word(OP_W'($urandom), 1'b0);
    fetch(15);
    check_val("full_last_word", 32'(b16.opcode), 32'(words[15]));
    fetch(9);
    check_val("d10_addr9_word", 32'(b10.opcode), 32'(words[9]));
    for (int a = 10; a < 16; a++) begin
      fetch(a);
      check_val("d10_oob_err", 32'(b10.fetch_err), 32'd1);
    end

    // load_start beats a same-cycle fetch; load_end with the third word.
    ls = 1'b1; fr = 1'b1; fa = '0;
    tick();
    set_idle();
    check_val("ls_fetch_err", 32'(b16.fetch_err), 32'd1);
    check_val("ls_busy", 32'(b16.busy), 32'd1);
    push_word(OP_W'(26'h0a1), 1'b0);
    push_word(OP_W'(26'h0a2), 1'b0);
    push_word(OP_W'(26'h0a3), 1'b1);
    check_val("end_on_w3_len", 32'(b16.prog_len), 32'd3);

    // Empty program: every fetch errors.
    start_load();
    le = 1'b1; tick(); le = 1'b0;
    check_val("empty_prog_len", 32'(b16.prog_len), 32'd0);
    for (int a = 0; a < 3; a++) fetch(a);

    // Restart mid-load; the word presented with load_start is discarded.
    start_load();
    for (int i = 0; i < 4; i++) push_word(OP_W'(26'h100 + i), 1'b0);
    ls = 1'b1; lv = 1'b1; ld = OP_W'(26'h3ff);
    tick();
    set_idle();
    push_word(OP_W'(26'h201), 1'b0);
    push_word(OP_W'(26'h202), 1'b1);
    check_val("restart_len", 32'(b16.prog_len), 32'd2);
    fetch(0);
    check_val("restart_w0", 32'(b16.opcode), 32'h201);
    fetch(1);
    check_val("restart_w1", 32'(b16.opcode), 32'h202);
    fetch(2);

    // Reset after three words.
    start_load();
    for (int i = 0; i < 3; i++) push_word(OP_W'(26'h300 + i), 1'b0);
    apply_reset();
    check_val("midload_rst_len", 32'(b16.prog_len), 32'd0);
    check_val("midload_rst_busy", 32'(b16.busy), 32'd0);
    fetch(0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        apply_reset();
      end else begin
        ls = ($urandom_range(0, 24) == 0);
        lv = ($urandom_range(0, 3) != 0);
        le = ($urandom_range(0, 11) == 0);
        ld = OP_W'($urandom);
        fr = ($urandom_range(0, 1) == 1);
        fa = AW'($urandom_range(0, 15));
        tick();
      end
    end
    set_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
